instr_fetch_unit: RTL and testbench

Instruction fetch unit for the RV32I core: owns the program counter, issues in-order word reads to instruction memory, buffers returned words in a small FIFO, and presents them with a valid/ready handshake to the instruction decoder, which consumes them whenever it asserts ready. Branch/jump resolution redirects the PC, discarding buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fifo.sv | 74 +++++++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: widths, PC step, reset PC, fetch FSM states.
// IFU_MISALIGN_CHECK_EN adds the FAULT state to the fetch FSM.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef IFU_MISALIGN_CHECK_EN
   typedef enum logic {
      FETCH_RUN,
      FETCH_FAULT
   } fetch_state_e;
`else
   typedef enum logic {
      FETCH_RUN
   } fetch_state_e;
`endif

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] word;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus: request address channel plus in-order response.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
   import riscv_pkg::*;

   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [XLEN-1:0]    imem_addr;
   logic               imem_resp_valid;
   logic [INSTR_W-1:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );

endinterface

// File: rtl/instr_fifo.sv
// Instruction buffer FIFO with flush; head output is registered state only.
// Output data reads as zero while the FIFO is empty.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign valid   = (count_q != '0);
   assign do_push = push && (count_q != CNT_W'(DEPTH));
   assign do_pop  = pop && valid;
   assign dout    = valid ? mem_q[rd_ptr_q] : '0;
   assign count   = count_q;

   // Pointer/count/storage update; flush empties the buffer outright.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: reads are gated by the count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch unit: PC, credit-limited imem requests, discard on redirect.
// IFU_MISALIGN_CHECK_EN: misaligned redirect target traps into sticky FAULT.
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   instr_fetch_unit_if.master    imem,
   output logic                  instr_valid,
   output logic [INSTR_W-1:0]    instr,
   output logic [XLEN-1:0]       instr_pc,
   input  logic                  decoder_ready,
   input  logic                  redirect_valid,
   input  logic [XLEN-1:0]       redirect_pc,
   output logic                  fetch_fault
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = CNT_W + 1;

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] discard_q, discard_d;
   logic [CNT_W-1:0] fifo_count;
   logic [XLEN-1:0]  target;
   logic             run, credit_ok, req_fire;
   logic             push, pop, flush, fifo_valid;
   fetch_entry_t     push_entry, head;

   assign run       = (state_q == FETCH_RUN);
   assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_q))
                      < SUM_W'(FIFO_DEPTH);

   assign imem.imem_req_valid = run && !reset && !redirect_valid && credit_ok;
   assign imem.imem_addr      = fetch_pc_q;
   assign req_fire = imem.imem_req_valid && imem.imem_req_ready;

`ifdef IFU_MISALIGN_CHECK_EN
   assign target      = redirect_pc;
   assign fetch_fault = (state_q == FETCH_FAULT);
`else
   assign target      = redirect_pc & ~XLEN'(3);
   assign fetch_fault = 1'b0;
`endif

   assign push_entry.pc   = resp_pc_q;
   assign push_entry.word = imem.imem_resp_data;

   assign instr_valid = fifo_valid && run;
   assign instr       = head.word;
   assign instr_pc    = head.pc;
   assign pop         = instr_valid && decoder_ready;

   // Fetch FSM, credit tracking and stale-response discard.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      discard_d  = discard_q;
      push       = 1'b0;
      flush      = 1'b0;
      inflight_d = inflight_q + CNT_W'(req_fire)
                 - CNT_W'(imem.imem_resp_valid);
      unique case (state_q)
         FETCH_RUN: begin
            if (req_fire) begin
               fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (imem.imem_resp_valid) begin
               if (discard_q != '0) begin
                  discard_d = discard_q - CNT_W'(1);
               end else begin
                  push      = 1'b1;
                  resp_pc_d = resp_pc_q + PC_STEP;
               end
            end
            if (redirect_valid) begin
               flush      = 1'b1;
               push       = 1'b0;
               fetch_pc_d = target;
               resp_pc_d  = target;
               discard_d  = inflight_d;
`ifdef IFU_MISALIGN_CHECK_EN
               if (redirect_pc[1:0] != 2'b00) begin
                  state_d = FETCH_FAULT;
               end
`endif
            end
         end
`ifdef IFU_MISALIGN_CHECK_EN
         FETCH_FAULT: begin
            flush = 1'b1;
         end
`endif
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH_RUN;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .valid (fifo_valid),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order latency memory model.
// Build with IFU_MISALIGN_CHECK_EN to exercise the fault path.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        decoder_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   int n_tests = 0;
   int n_fail  = 0;
   int lat     = 1;
   int cyc     = 0;

   typedef struct {
      logic [31:0] a;
      int          due;
   } pend_t;

   pend_t pend[$];

   instr_fetch_unit_if bus();

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (rst),
      .imem           (bus),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .decoder_ready  (decoder_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic go(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Memory model: accepts at negedge, answers in order after lat cycles.
   initial begin
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst || pend.size() == 0 || pend[0].due > cyc) begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
         end else begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(pend[0].a);
            void'(pend.pop_front());
         end
         @(negedge clk);
         if (rst) begin
            pend.delete();
         end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{a: bus.imem_addr, due: cyc + lat});
         end
      end
   end

   // Ends at the start of cycle 0 (first cycle with reset low).
   task automatic do_reset(int l, logic d);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      lat            = l;
      decoder_ready  = d;
      go(1);
      smp();
      check("rst_req_valid", 32'(bus.imem_req_valid), 0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_fault", 32'(fetch_fault), 0);
      go(1);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      rst            = 1'b1;
      decoder_ready  = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Streaming: back-to-back requests and deliveries.
      do_reset(1, 1'b1);
      smp();
      check("t1_c0_req_valid", 32'(bus.imem_req_valid), 1);
      check("t1_c0_addr", bus.imem_addr, 32'h0);
      check("t1_c0_ivalid", 32'(instr_valid), 0);
      go(1); smp();
      check("t1_c1_addr", bus.imem_addr, 32'h4);
      check("t1_c1_ivalid", 32'(instr_valid), 0);
      go(1); smp();
      check("t1_c2_addr", bus.imem_addr, 32'h8);
      check("t1_c2_ivalid", 32'(instr_valid), 1);
      check("t1_c2_pc", instr_pc, 32'h0);
      check("t1_c2_instr", instr, mem_word(32'h0));
      go(1); smp();
      check("t1_c3_pc", instr_pc, 32'h4);
      go(1); smp();
      check("t1_c4_pc", instr_pc, 32'h8);
      check("t1_c4_instr", instr, mem_word(32'h8));

      // Decoder stalled: credit limit stops requests at FIFO_DEPTH.
      do_reset(1, 1'b0);
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         smp();
         if (bus.imem_req_valid && bus.imem_req_ready) acc++;
         if (i == 9) check("t2_req_valid_full", 32'(bus.imem_req_valid), 0);
         go(1);
      end
      check("t2_req_count", 32'(acc), 4);
      decoder_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         smp();
         check("t2_drain_ivalid", 32'(instr_valid), 1);
         check("t2_drain_pc", instr_pc, 32'(4 * i));
         check("t2_drain_instr", instr, mem_word(32'(4 * i)));
         go(1);
      end

      // Latency 3: redirect with two requests in flight.
      do_reset(3, 1'b1);
      go(2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      smp();
      check("t3_redir_req_valid", 32'(bus.imem_req_valid), 0);
      go(1);
      redirect_valid = 1'b0;
      smp();
      check("t3_c3_req_valid", 32'(bus.imem_req_valid), 1);
      check("t3_c3_addr", bus.imem_addr, 32'h100);
      check("t3_c3_ivalid", 32'(instr_valid), 0);
      for (int i = 4; i < 7; i++) begin
         go(1); smp();
         check("t3_stale_ivalid", 32'(instr_valid), 0);
      end
      go(1); smp();
      check("t3_c7_ivalid", 32'(instr_valid), 1);
      check("t3_c7_pc", instr_pc, 32'h100);
      check("t3_c7_instr", instr, mem_word(32'h100));
      go(1); smp();
      check("t3_c8_pc", instr_pc, 32'h104);

      // Redirect coinciding with a pop and a response.
      do_reset(1, 1'b1);
      go(2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      smp();
      check("t4_pop_ivalid", 32'(instr_valid), 1);
      check("t4_pop_pc", instr_pc, 32'h0);
      check("t4_pop_req_valid", 32'(bus.imem_req_valid), 0);
      go(1);
      redirect_valid = 1'b0;
      smp();
      check("t4_c3_ivalid", 32'(instr_valid), 0);
      check("t4_c3_addr", bus.imem_addr, 32'h200);
      check("t4_c3_req_valid", 32'(bus.imem_req_valid), 1);
      go(1); smp();
      check("t4_c4_ivalid", 32'(instr_valid), 0);
      go(1); smp();
      check("t4_c5_ivalid", 32'(instr_valid), 1);
      check("t4_c5_pc", instr_pc, 32'h200);
      check("t4_c5_instr", instr, mem_word(32'h200));

      // Misaligned redirect target.
      do_reset(1, 1'b1);
      go(2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      go(1);
      redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      smp();
      check("t5_fault", 32'(fetch_fault), 1);
      check("t5_req_valid", 32'(bus.imem_req_valid), 0);
      check("t5_ivalid", 32'(instr_valid), 0);
      for (int i = 0; i < 4; i++) begin
         go(1); smp();
         check("t5_hold_fault", 32'(fetch_fault), 1);
         check("t5_hold_req_valid", 32'(bus.imem_req_valid), 0);
         check("t5_hold_ivalid", 32'(instr_valid), 0);
      end
`else
      smp();
      check("t5_fault", 32'(fetch_fault), 0);
      check("t5_req_valid", 32'(bus.imem_req_valid), 1);
      check("t5_addr", bus.imem_addr, 32'h100);
      go(2); smp();
      check("t5_ivalid", 32'(instr_valid), 1);
      check("t5_pc", instr_pc, 32'h100);
`endif

      // PC wrap at the top of the address space.
      do_reset(1, 1'b1);
      go(2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      go(1);
      redirect_valid = 1'b0;
      smp();
      check("t6_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      go(1); smp();
      check("t6_addr_wrap", bus.imem_addr, 32'h0);
      go(1); smp();
      check("t6_pc_top", instr_pc, 32'hFFFF_FFFC);
      check("t6_instr_top", instr, mem_word(32'hFFFF_FFFC));
      go(1); smp();
      check("t6_pc_wrap", instr_pc, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
